// File: rtl/accel_spi_sequencer_if.sv
// Pin-level and sample-output bundle between the ADXL362 sequencer and its
// surroundings (sensor pins plus the registered Y/Z sample outputs).
interface accel_spi_sequencer_if;
  logic        MISO;
  logic        MOSI;
  logic        SCLK;
  logic        CS;
  logic [15:0] Y_value;
  logic [15:0] Z_value;
  logic        valid;
  logic        init_done;
  logic        busy;

  // valid is a one-cycle strobe with no back-pressure: the consumer must
  // capture Y_value/Z_value on the cycle valid is high.
  modport master (
    input  MISO,
    output MOSI, SCLK, CS, Y_value, Z_value, valid, init_done, busy
  );

  modport slave (
    output MISO,
    input  MOSI, SCLK, CS, Y_value, Z_value, valid, init_done, busy
  );
endinterface

// File: rtl/accel_spi_sequencer.sv
// ADXL362 SPI sequencer: one POWER_CTL=measure write after reset, then
// periodic Y/Z burst reads presented as registered words with a valid strobe.
module accel_spi_sequencer #(
  parameter int CLK_DIV       = 50,
  parameter int SAMPLE_PERIOD = 1000000,
  parameter int CS_IDLE       = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  accel_spi_sequencer_if.master        spi,
  output logic [2:0]                   state_dbg
);

  localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CMAX = (SAMPLE_PERIOD > CS_IDLE) ? SAMPLE_PERIOD : CS_IDLE;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE   = DW'(1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(CS_IDLE - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(SAMPLE_PERIOD - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  // Commands are left-aligned; the trailing zeros keep MOSI low while the
  // read data bytes come back.
  localparam logic [23:0] INIT_CMD  = 24'h0A2D02;
  localparam logic [23:0] READ_CMD  = 24'h0B1000;
  // Half-period index of the CS hold phase (2N) and of the first data rise.
  localparam logic [6:0]  INIT_HOLD = 7'd48;
  localparam logic [6:0]  READ_HOLD = 7'd96;
  localparam logic [6:0]  RX_FIRST  = 7'd33;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_INIT_XFER = 3'd1,
    ST_GAP       = 3'd2,
    ST_WAIT      = 3'd3,
    ST_READ_XFER = 3'd4,
    ST_UPDATE    = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic          cs_q, cs_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          busy_q;
  logic          valid_q, valid_d;
  logic          init_done_q, init_done_d;
  logic [15:0]   y_q, y_d;
  logic [15:0]   z_q, z_d;
  logic [23:0]   tx_q, tx_d;
  logic [31:0]   rx_q, rx_d;
  logic [DW-1:0] div_q, div_d;
  logic [6:0]    half_q, half_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          in_xfer;
  logic          cell_end;
  logic          xfer_done;
  logic          gap_end;
  logic          wait_end;
  logic [6:0]    hold_half;
  logic [6:0]    half_nx;
  logic          start_xfer;
  logic [23:0]   start_cmd;

  assign in_xfer   = (state_q == ST_INIT_XFER) || (state_q == ST_READ_XFER);
  assign cell_end  = in_xfer && (div_q == DIV_LAST);
  assign hold_half = (state_q == ST_READ_XFER) ? READ_HOLD : INIT_HOLD;
  assign xfer_done = cell_end && (half_q == hold_half);
  assign gap_end   = (cnt_q == GAP_LAST);
  assign wait_end  = (cnt_q == WAIT_LAST);
  assign half_nx   = half_q + 7'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:     state_d = ST_INIT_XFER;
      ST_INIT_XFER: if (xfer_done) state_d = ST_GAP;
      ST_READ_XFER: if (xfer_done) state_d = ST_UPDATE;
      ST_UPDATE:    state_d = gap_end ? ST_WAIT : ST_GAP;
      ST_GAP:       if (gap_end) state_d = ST_WAIT;
      ST_WAIT:      if (wait_end) state_d = ST_READ_XFER;
      default:      state_d = ST_RESET;
    endcase
  end

  // Next values of every registered output and datapath register.
  always_comb begin
    cs_d        = cs_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    div_d       = div_q;
    half_d      = half_q;
    cnt_d       = cnt_q;
    y_d         = y_q;
    z_d         = z_q;
    valid_d     = 1'b0;
    init_done_d = init_done_q;
    start_xfer  = 1'b0;
    start_cmd   = READ_CMD;
    case (state_q)
      ST_RESET: begin
        start_xfer = 1'b1;
        start_cmd  = INIT_CMD;
      end
      ST_INIT_XFER, ST_READ_XFER: begin
        if (xfer_done) begin
          cs_d   = 1'b1;
          sclk_d = 1'b0;
          mosi_d = 1'b0;
          cnt_d  = '0;
          if (state_q == ST_READ_XFER) begin
            // Bytes arrived YL, YH, ZL, ZH.
            y_d     = {rx_q[23:16], rx_q[31:24]};
            z_d     = {rx_q[7:0], rx_q[15:8]};
            valid_d = 1'b1;
          end else begin
            init_done_d = 1'b1;
          end
        end else if (cell_end) begin
          div_d  = '0;
          half_d = half_nx;
          sclk_d = half_nx[0];
          if (!half_nx[0]) begin
            mosi_d = tx_q[23];
            tx_d   = {tx_q[22:0], 1'b0};
          end else if ((state_q == ST_READ_XFER) && (half_nx >= RX_FIRST)) begin
            rx_d = {rx_q[30:0], spi.MISO};
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      ST_GAP, ST_UPDATE: cnt_d = gap_end ? '0 : cnt_q + CNT_ONE;
      ST_WAIT: begin
        if (wait_end) start_xfer = 1'b1;
        else          cnt_d = cnt_q + CNT_ONE;
      end
      default: ;
    endcase
    if (start_xfer) begin
      cs_d   = 1'b0;
      sclk_d = 1'b0;
      div_d  = '0;
      half_d = '0;
      mosi_d = start_cmd[23];
      tx_d   = {start_cmd[22:0], 1'b0};
      rx_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_q        <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      init_done_q <= 1'b0;
      y_q         <= '0;
      z_q         <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      div_q       <= '0;
      half_q      <= '0;
      cnt_q       <= '0;
    end else begin
      cs_q        <= cs_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      busy_q      <= ~cs_d;
      valid_q     <= valid_d;
      init_done_q <= init_done_d;
      y_q         <= y_d;
      z_q         <= z_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      div_q       <= div_d;
      half_q      <= half_d;
      cnt_q       <= cnt_d;
    end
  end

  assign spi.CS        = cs_q;
  assign spi.SCLK      = sclk_q;
  assign spi.MOSI      = mosi_q;
  assign spi.busy      = busy_q;
  assign spi.valid     = valid_q;
  assign spi.init_done = init_done_q;
  assign spi.Y_value   = y_q;
  assign spi.Z_value   = z_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_accel_spi_sequencer.sv
// Bench for accel_spi_sequencer: mode-0 slave model, protocol monitor and
// per-scenario checks against values derived from the transfer rules.
module tb_accel_spi_sequencer;
  localparam int CLK_DIV       = 2;
  localparam int SAMPLE_PERIOD = 20;
  localparam int CS_IDLE       = 4;
  localparam int INIT_LOW      = (2 * 24 + 1) * CLK_DIV;
  localparam int READ_LOW      = (2 * 48 + 1) * CLK_DIV;
  localparam int GAP_CYC       = CS_IDLE + SAMPLE_PERIOD;
  localparam int PERIOD        = READ_LOW + GAP_CYC;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] state_dbg;

  accel_spi_sequencer_if spi ();

  accel_spi_sequencer #(
    .CLK_DIV      (CLK_DIV),
    .SAMPLE_PERIOD(SAMPLE_PERIOD),
    .CS_IDLE      (CS_IDLE)
  ) dut (
    .clk      (clk),
    .reset    (rst),
    .spi      (spi),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- slave model + monitor ----------------
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          proto_viol = 0;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  logic        prev_mosi = 1'b0;
  int          phase_len = 0;
  int          rise_cnt = 0;
  int          low_cnt = 0;
  logic [47:0] mosi_sr = '0;
  logic [47:0] resp = '0;
  int          xfer_count = 0;
  int          last_bits = 0;
  logic [47:0] last_mosi = '0;
  int          last_low = 0;
  logic        last_init_done = 1'b0;
  int          last_rise_cyc = -1;
  int          last_gap = -1;
  int          valid_count = 0;
  int          last_valid_cyc = -1;
  int          prev_valid_cyc = -1;
  logic [15:0] last_y = '0;
  logic [15:0] last_z = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      spi.MISO = 1'b0;
      rise_cnt = 0;
      low_cnt  = 0;
    end else begin
      if (spi.busy !== ~spi.CS) begin
        proto_viol++;
        $display("protocol violation: busy=%b CS=%b at cycle %0d", spi.busy, spi.CS, cyc);
      end
      if (prev_cs && !spi.CS) begin
        if (spi.SCLK !== 1'b0) begin
          proto_viol++;
          $display("protocol violation: SCLK high at CS fall, cycle %0d", cyc);
        end
        rise_cnt  = 0;
        mosi_sr   = '0;
        low_cnt   = 1;
        phase_len = 1;
        last_gap  = (last_rise_cyc >= 0) ? cyc - last_rise_cyc : -1;
        spi.MISO  = resp[47];
      end else if (!spi.CS) begin
        low_cnt++;
        if (spi.SCLK !== prev_sclk) begin
          if (phase_len != CLK_DIV) begin
            proto_viol++;
            $display("protocol violation: SCLK phase %0d cycles, cycle %0d", phase_len, cyc);
          end
          phase_len = 1;
          if (spi.SCLK) begin
            mosi_sr = {mosi_sr[46:0], spi.MOSI};
            rise_cnt++;
          end else if (rise_cnt < 48) begin
            spi.MISO = resp[47 - rise_cnt];
          end
        end else begin
          phase_len++;
          if (spi.SCLK && (spi.MOSI !== prev_mosi)) begin
            proto_viol++;
            $display("protocol violation: MOSI moved while SCLK high, cycle %0d", cyc);
          end
        end
      end else if (!prev_cs && spi.CS) begin
        if (spi.SCLK !== 1'b0) begin
          proto_viol++;
          $display("protocol violation: SCLK high at CS rise, cycle %0d", cyc);
        end
        last_bits      = rise_cnt;
        last_mosi      = mosi_sr;
        last_low       = low_cnt;
        last_init_done = spi.init_done;
        last_rise_cyc  = cyc;
        xfer_count++;
      end
      if (spi.valid === 1'b1) begin
        valid_count++;
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc;
        last_y         = spi.Y_value;
        last_z         = spi.Z_value;
        if (!(!prev_cs && spi.CS)) begin
          proto_viol++;
          $display("protocol violation: valid not on CS rise, cycle %0d", cyc);
        end
      end
    end
    prev_cs   = spi.CS;
    prev_sclk = spi.SCLK;
    prev_mosi = spi.MOSI;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_xfer(input int budget, output bit ok);
    int start;
    start = xfer_count;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (xfer_count != start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (spi.CS !== 1'b1)        begin errors++; $display("FAIL reset_cs: got %b want 1", spi.CS); end
    checks++; if (spi.SCLK !== 1'b0)      begin errors++; $display("FAIL reset_sclk: got %b want 0", spi.SCLK); end
    checks++; if (spi.MOSI !== 1'b0)      begin errors++; $display("FAIL reset_mosi: got %b want 0", spi.MOSI); end
    checks++; if (spi.Y_value !== 16'h0)  begin errors++; $display("FAIL reset_y: got %h want 0000", spi.Y_value); end
    checks++; if (spi.Z_value !== 16'h0)  begin errors++; $display("FAIL reset_z: got %h want 0000", spi.Z_value); end
    checks++; if (spi.valid !== 1'b0)     begin errors++; $display("FAIL reset_valid: got %b want 0", spi.valid); end
    checks++; if (spi.init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b want 0", spi.init_done); end
    checks++; if (spi.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", spi.busy); end
  endtask

  task automatic test_init(input string tag);
    bit ok;
    int v0;
    v0 = valid_count;
    resp = {$urandom(), $urandom_range(0, 65535)};
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (spi.CS !== 1'b0)        begin errors++; $display("FAIL %s_cs_first_edge: got %b want 0", tag, spi.CS); end
    checks++; if (spi.init_done !== 1'b0) begin errors++; $display("FAIL %s_init_done_early: got %b want 0", tag, spi.init_done); end
    wait_xfer(INIT_LOW + 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_timeout: got no CS rise want one within %0d cycles", tag, INIT_LOW + 50); end
    checks++; if (last_bits != 24)               begin errors++; $display("FAIL %s_bits: got %0d want 24", tag, last_bits); end
    checks++; if (last_mosi[23:0] !== 24'h0A2D02) begin errors++; $display("FAIL %s_mosi: got %h want 0a2d02", tag, last_mosi[23:0]); end
    checks++; if (last_low != INIT_LOW)          begin errors++; $display("FAIL %s_cs_low: got %0d want %0d", tag, last_low, INIT_LOW); end
    checks++; if (last_init_done !== 1'b1)       begin errors++; $display("FAIL %s_init_done: got %b want 1", tag, last_init_done); end
    checks++; if (valid_count != v0)             begin errors++; $display("FAIL %s_no_valid: got %0d pulses want 0", tag, valid_count - v0); end
  endtask

  task automatic test_read(input string tag, input logic [15:0] yv, input logic [15:0] zv,
                           input logic [15:0] fill);
    bit ok;
    int v0;
    for (int i = 0; i < PERIOD && spi.CS !== 1'b1; i++) @(negedge clk);
    #1;
    // Wire order after the command: YL, YH, ZL, ZH.
    resp = {fill, yv[7:0], yv[15:8], zv[7:0], zv[15:8]};
    v0 = valid_count;
    wait_xfer(PERIOD + 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_timeout: got no CS rise want one within %0d cycles", tag, PERIOD + 50); end
    checks++; if (last_bits != 48)                          begin errors++; $display("FAIL %s_bits: got %0d want 48", tag, last_bits); end
    checks++; if (last_mosi !== 48'h0B10_0000_0000)         begin errors++; $display("FAIL %s_mosi: got %h want 0b1000000000", tag, last_mosi); end
    checks++; if (last_low != READ_LOW)                     begin errors++; $display("FAIL %s_cs_low: got %0d want %0d", tag, last_low, READ_LOW); end
    checks++; if (last_gap != GAP_CYC)                      begin errors++; $display("FAIL %s_cs_gap: got %0d want %0d", tag, last_gap, GAP_CYC); end
    checks++; if (valid_count != v0 + 1)                    begin errors++; $display("FAIL %s_valid_count: got %0d want 1", tag, valid_count - v0); end
    checks++; if (last_y !== yv)                            begin errors++; $display("FAIL %s_y: got %h want %h", tag, last_y, yv); end
    checks++; if (last_z !== zv)                            begin errors++; $display("FAIL %s_z: got %h want %h", tag, last_z, zv); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] yv, zv;
    for (int i = 0; i < 3; i++) begin
      yv = 16'($urandom_range(1, 65535));
      zv = 16'($urandom_range(1, 65535));
      test_read($sformatf("b2b%0d", i), yv, zv, 16'($urandom_range(0, 65535)));
      checks++;
      if (last_valid_cyc - prev_valid_cyc != PERIOD) begin
        errors++;
        $display("FAIL b2b%0d_valid_spacing: got %0d want %0d", i, last_valid_cyc - prev_valid_cyc, PERIOD);
      end
    end
  endtask

  task automatic test_cmd_miso_ignored();
    test_read("cmd_ones", 16'h0000, 16'h0000, 16'hFFFF);
  endtask

  task automatic test_reset_mid_read();
    bit hit;
    hit = 1'b0;
    resp = {16'hA5A5, 8'h12, 8'h34, 8'h56, 8'h78};
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(negedge clk);
      #1;
      if (spi.CS === 1'b0 && rise_cnt == 30) begin
        hit = 1'b1;
        break;
      end
    end
    checks++; if (!hit) begin errors++; $display("FAIL midrst_reach_bit30: got no bit 30 want one"); end
    checks++; if (spi.Y_value === 16'h0) begin errors++; $display("FAIL midrst_y_before: got 0000 want nonzero"); end
    rst = 1'b1;
    #1;
    checks++; if (spi.CS !== 1'b1)        begin errors++; $display("FAIL midrst_cs: got %b want 1", spi.CS); end
    checks++; if (spi.SCLK !== 1'b0)      begin errors++; $display("FAIL midrst_sclk: got %b want 0", spi.SCLK); end
    checks++; if (spi.Y_value !== 16'h0)  begin errors++; $display("FAIL midrst_y: got %h want 0000", spi.Y_value); end
    checks++; if (spi.Z_value !== 16'h0)  begin errors++; $display("FAIL midrst_z: got %h want 0000", spi.Z_value); end
    checks++; if (spi.init_done !== 1'b0) begin errors++; $display("FAIL midrst_init_done: got %b want 0", spi.init_done); end
    checks++; if (spi.busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy: got %b want 0", spi.busy); end
    repeat (3) @(negedge clk);
    test_init("reinit");
    checks++; if (spi.Y_value !== 16'h0) begin errors++; $display("FAIL reinit_y_cleared: got %h want 0000", spi.Y_value); end
    test_read("after_reset", 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
              16'($urandom_range(0, 65535)));
  endtask

  task automatic test_protocol();
    checks++;
    if (proto_viol != 0) begin
      errors++;
      $display("FAIL protocol: got %0d violations want 0", proto_viol);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_init("init");
    test_read("read_basic", 16'h0134, 16'hFFF0, 16'h0000);
    test_back_to_back();
    test_cmd_miso_ignored();
    test_read("read_rand", 16'($urandom_range(1, 65535)), 16'($urandom_range(1, 65535)), 16'hFFFF);
    test_reset_mid_read();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
